// File: rtl/axi4_lite_arbiter.sv
// rtl/axi4_lite_arbiter.sv - round-robin arbiter sharing one AXI4-Lite manager port between NUM_REQ requesters
// Issues combinationally from idle and holds the winner's latched operands until the manager completes.
module axi4_lite_arbiter #(
  parameter  int NUM_REQ    = 2,
  parameter  int ADDR_WIDTH = 32,
  parameter  int XLEN       = 32,
  localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_rd_en,
  input  logic [NUM_REQ-1:0]                 req_wr_en,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0][XLEN-1:0]       req_wr_data,
  input  logic [NUM_REQ-1:0][XLEN/8-1:0]     req_wr_strobe,
  output logic [XLEN-1:0]                    req_rd_data,
  output logic [NUM_REQ-1:0]                 req_fault,
  output logic [NUM_REQ-1:0]                 req_busy,
  output logic [GW-1:0]                      grant,
  output logic                               mgr_rd_en,
  output logic                               mgr_wr_en,
  output logic [ADDR_WIDTH-1:0]              mgr_addr,
  output logic [XLEN-1:0]                    mgr_wr_data,
  output logic [XLEN/8-1:0]                  mgr_wr_strobe,
  input  logic [XLEN-1:0]                    mgr_rd_data,
  input  logic                               mgr_fault,
  input  logic                               mgr_busy
);

  typedef enum logic {ARB_IDLE = 1'b0, ARB_ACTIVE = 1'b1} arb_state_e;

  arb_state_e            state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [XLEN/8-1:0]     strb_q, strb_d;

  logic [NUM_REQ-1:0]    req_v;
  logic                  any_req;
  logic [GW-1:0]         winner;
  logic [GW-1:0]         cand;
  logic                  issue;
  logic                  complete;

  // Gating with rst_n keeps the combinational issue path silent while reset is held.
  assign req_v    = (req_rd_en | req_wr_en) & {NUM_REQ{rst_n}};
  assign any_req  = |req_v;
  assign issue    = (state_q == ARB_IDLE) & any_req;
  assign complete = (state_q == ARB_ACTIVE) & ~mgr_busy;

  // Scanning downwards lets the last hit be the nearest requester after last_grant_q.
  always_comb begin
    winner = last_grant_q;
    cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (req_v[cand]) winner = cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    case (state_q)
      ARB_IDLE: begin
        if (issue) begin
          addr_d  = req_addr[winner];
          wdata_d = req_wr_data[winner];
          strb_d  = req_wr_strobe[winner];
          grant_d = winner;
          state_d = ARB_ACTIVE;
        end
      end
      ARB_ACTIVE: begin
        if (complete) begin
          last_grant_d = grant_q;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Manager-side outputs never look at mgr_busy, which the manager derives from the enables.
  always_comb begin
    mgr_rd_en     = 1'b0;
    mgr_wr_en     = 1'b0;
    mgr_addr      = addr_q;
    mgr_wr_data   = wdata_q;
    mgr_wr_strobe = strb_q;
    if (state_q == ARB_IDLE) begin
      mgr_rd_en     = issue & req_rd_en[winner];
      mgr_wr_en     = issue & req_wr_en[winner] & ~req_rd_en[winner];
      mgr_addr      = issue ? req_addr[winner]      : '0;
      mgr_wr_data   = issue ? req_wr_data[winner]   : '0;
      mgr_wr_strobe = issue ? req_wr_strobe[winner] : '0;
    end
  end

  // A grantee that withdrew its request mid-transaction neither stalls nor sees the fault.
  always_comb begin
    req_busy    = req_v;
    req_fault   = '0;
    req_rd_data = complete ? mgr_rd_data : '0;
    grant       = issue ? winner : grant_q;
    if (issue) req_busy[winner] = mgr_busy;
    if (state_q == ARB_ACTIVE) begin
      req_busy[grant_q]  = mgr_busy & req_v[grant_q];
      req_fault[grant_q] = complete & req_v[grant_q] & mgr_fault;
    end
  end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// tb/tb_axi4_lite_arbiter.sv - self-checking bench for axi4_lite_arbiter
// Vector table, directed corner sequences and a randomized run against a transaction-level model.
module tb_axi4_lite_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int XL = 32;

  logic                   clk;
  logic                   rst_n;
  logic [N-1:0]           req_rd_en;
  logic [N-1:0]           req_wr_en;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][XL-1:0]   req_wr_data;
  logic [N-1:0][XL/8-1:0] req_wr_strobe;
  logic [XL-1:0]          req_rd_data;
  logic [N-1:0]           req_fault;
  logic [N-1:0]           req_busy;
  logic [0:0]             grant;
  logic                   mgr_rd_en;
  logic                   mgr_wr_en;
  logic [AW-1:0]          mgr_addr;
  logic [XL-1:0]          mgr_wr_data;
  logic [XL/8-1:0]        mgr_wr_strobe;
  logic [XL-1:0]          mgr_rd_data;
  logic                   mgr_fault;
  logic                   mgr_busy;

  int checks;
  int errors;
  int mgr_cnt;
  int lat;

  // Manager: busy in the issue cycle, then lat-1 further busy cycles, then one not-busy completion cycle.
  assign mgr_busy = mgr_rd_en | mgr_wr_en | (mgr_cnt != 0);

  axi4_lite_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .XLEN(XL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_rd_en(req_rd_en), .req_wr_en(req_wr_en), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .req_wr_strobe(req_wr_strobe),
    .req_rd_data(req_rd_data), .req_fault(req_fault), .req_busy(req_busy), .grant(grant),
    .mgr_rd_en(mgr_rd_en), .mgr_wr_en(mgr_wr_en), .mgr_addr(mgr_addr),
    .mgr_wr_data(mgr_wr_data), .mgr_wr_strobe(mgr_wr_strobe),
    .mgr_rd_data(mgr_rd_data), .mgr_fault(mgr_fault), .mgr_busy(mgr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic adv();
    logic iss;
    iss = mgr_rd_en | mgr_wr_en;
    @(posedge clk);
    #1;
    if (!rst_n)           mgr_cnt = 0;
    else if (iss)         mgr_cnt = lat - 1;
    else if (mgr_cnt > 0) mgr_cnt--;
    @(negedge clk);
  endtask

  task automatic clear_req();
    req_rd_en     = '0;
    req_wr_en     = '0;
    req_addr      = '0;
    req_wr_data   = '0;
    req_wr_strobe = '0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    clear_req();
    mgr_cnt     = 0;
    mgr_fault   = 1'b0;
    mgr_rd_data = '0;
    adv();
    adv();
    rst_n = 1'b1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] a, input int last);
    int w;
    w = -1;
    for (int k = 1; k <= N; k++)
      if (w < 0 && a[(last + k) % N]) w = (last + k) % N;
    return w;
  endfunction

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic        e_grant;
    logic [1:0]  e_busy;
  } vec_t;

  vec_t        tbl [7];
  logic [1:0]  gbit;
  logic        is_iss;
  int          pulses;
  int          nissue;
  logic [0:0]  gseq [4];

  logic [N-1:0]         act;
  logic [N-1:0]         m_rd, m_wr;
  logic [AW-1:0]        m_addr [N];
  logic [XL-1:0]        m_data [N];
  logic [XL/8-1:0]      m_strb [N];
  logic [1:0]           op;
  int                   m_last, tg, trem, w;
  logic                 tx, done, chk_g;
  logic [AW-1:0]        t_addr;
  logic [XL-1:0]        t_data, t_rdata;
  logic [XL/8-1:0]      t_strb;
  logic                 t_fault;
  logic                 e_rd, e_wr;
  logic [AW-1:0]        e_addr;
  logic [XL-1:0]        e_data;
  logic [XL/8-1:0]      e_strb;
  logic [N-1:0]         e_busy, e_fault;
  logic [0:0]           e_grant;

  initial begin
    checks = 0; errors = 0; mgr_cnt = 0; lat = 1;
    rst_n = 1'b0; mgr_rd_data = '0; mgr_fault = 1'b0;
    clear_req();
    @(negedge clk);

    // Outputs stay zero under reset even with requests asserted.
    req_rd_en = 2'b11; req_wr_en = 2'b01; req_addr[0] = 32'h1234;
    req_wr_data[0] = 32'h5555_AAAA; req_wr_strobe[0] = 4'hF;
    #1;
    chk("rst_mgr_en", {mgr_rd_en, mgr_wr_en}, 0);
    chk("rst_mgr_addr", mgr_addr, 0);
    chk("rst_mgr_wdata", mgr_wr_data, 0);
    chk("rst_mgr_strb", mgr_wr_strobe, 0);
    chk("rst_busy", req_busy, 0);
    chk("rst_fault", req_fault, 0);
    chk("rst_grant", grant, 0);
    chk("rst_rdata", req_rd_data, 0);
    clear_req();
    adv();
    rst_n = 1'b1;

    tbl[0] = '{2'b01, 2'b00, 32'h100, 32'h200, 1'b1, 1'b0, 32'h100, 1'b0, 2'b01};
    tbl[1] = '{2'b11, 2'b00, 32'h104, 32'h204, 1'b1, 1'b0, 32'h204, 1'b1, 2'b11};
    tbl[2] = '{2'b01, 2'b11, 32'h108, 32'h208, 1'b1, 1'b0, 32'h108, 1'b0, 2'b11};
    tbl[3] = '{2'b00, 2'b10, 32'h10C, 32'h20C, 1'b0, 1'b1, 32'h20C, 1'b1, 2'b10};
    tbl[4] = '{2'b00, 2'b10, 32'h110, 32'h210, 1'b0, 1'b1, 32'h210, 1'b1, 2'b10};
    tbl[5] = '{2'b10, 2'b01, 32'h114, 32'h214, 1'b0, 1'b1, 32'h114, 1'b0, 2'b11};
    tbl[6] = '{2'b00, 2'b00, 32'h118, 32'h218, 1'b0, 1'b0, 32'h000, 1'b0, 2'b00};

    for (int v = 0; v < 7; v++) begin
      req_rd_en = tbl[v].rd; req_wr_en = tbl[v].wr;
      req_addr[0] = tbl[v].a0; req_addr[1] = tbl[v].a1;
      req_wr_data[0] = tbl[v].a0 ^ 32'hA5A5_0000; req_wr_data[1] = tbl[v].a1 ^ 32'hA5A5_0000;
      req_wr_strobe[0] = 4'h3; req_wr_strobe[1] = 4'hC;
      is_iss = tbl[v].e_rd | tbl[v].e_wr;
      #1;
      chk($sformatf("vec%0d_en", v), {mgr_rd_en, mgr_wr_en}, {tbl[v].e_rd, tbl[v].e_wr});
      chk($sformatf("vec%0d_addr", v), mgr_addr, tbl[v].e_addr);
      chk($sformatf("vec%0d_wdata", v), mgr_wr_data, is_iss ? (tbl[v].e_addr ^ 32'hA5A5_0000) : 32'h0);
      chk($sformatf("vec%0d_strb", v), mgr_wr_strobe, is_iss ? (tbl[v].e_grant ? 4'hC : 4'h3) : 4'h0);
      chk($sformatf("vec%0d_grant", v), grant, tbl[v].e_grant);
      chk($sformatf("vec%0d_busy", v), req_busy, tbl[v].e_busy);
      if (is_iss) begin
        lat = 1;
        adv();
        #1;
        gbit = 2'b01 << tbl[v].e_grant;
        chk($sformatf("vec%0d_done_busy", v), req_busy, tbl[v].e_busy & ~gbit);
        chk($sformatf("vec%0d_hold_addr", v), mgr_addr, tbl[v].e_addr);
      end
      clear_req();
      adv();
    end

    // Single read with three busy cycles.
    do_reset();
    lat = 3; mgr_rd_data = 32'hDEAD_BEEF; pulses = 0;
    req_rd_en = 2'b01; req_addr[0] = 32'h1000;
    for (int c = 0; c < 5; c++) begin
      #1;
      pulses += int'(mgr_rd_en);
      if (c < 3) chk($sformatf("t1_busy_c%0d", c), req_busy[0], 1'b1);
      if (c == 1) chk("t1_addr", mgr_addr, 32'h1000);
      if (c == 3) begin
        chk("t1_busy_done", req_busy[0], 1'b0);
        chk("t1_rdata", req_rd_data, 32'hDEAD_BEEF);
        clear_req();
      end
      adv();
    end
    chk("t1_rd_pulses", pulses, 1);

    // Simultaneous read and write: read first, write back-to-back.
    do_reset();
    lat = 2;
    req_rd_en = 2'b01; req_addr[0] = 32'h10;
    req_wr_en = 2'b10; req_addr[1] = 32'h20; req_wr_data[1] = 32'hA5A5_A5A5; req_wr_strobe[1] = 4'hF;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c <= 2) chk($sformatf("t2_busy1_c%0d", c), req_busy[1], 1'b1);
      if (c == 0) begin
        chk("t2_rd_issue", {mgr_rd_en, mgr_wr_en}, 2'b10);
        chk("t2_rd_addr", mgr_addr, 32'h10);
        chk("t2_grant0", grant, 0);
      end
      if (c == 2) begin
        chk("t2_busy0_done", req_busy[0], 1'b0);
        req_rd_en[0] = 1'b0;
      end
      if (c == 3) begin
        chk("t2_wr_issue", {mgr_rd_en, mgr_wr_en}, 2'b01);
        chk("t2_wr_addr", mgr_addr, 32'h20);
        chk("t2_wr_data", mgr_wr_data, 32'hA5A5_A5A5);
        chk("t2_wr_strb", mgr_wr_strobe, 4'hF);
        chk("t2_grant1", grant, 1);
      end
      if (c == 5) begin
        chk("t2_busy1_done", req_busy[1], 1'b0);
        clear_req();
      end
      adv();
    end

    // Continuous contention alternates grants.
    do_reset();
    lat = 1; nissue = 0;
    req_rd_en = 2'b11; req_addr[0] = 32'h30; req_addr[1] = 32'h34;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (mgr_rd_en) begin
        if (nissue < 4) gseq[nissue] = grant;
        nissue++;
      end
      adv();
    end
    clear_req();
    adv();
    chk("t3_issues", nissue, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("t3_grant%0d", k), gseq[k], k % 2);

    // Fault on requester 1, then normal arbitration.
    do_reset();
    lat = 2; mgr_fault = 1'b1; mgr_rd_data = 32'h0BAD_0BAD;
    req_rd_en = 2'b10; req_addr[1] = 32'h300; req_addr[0] = 32'h400;
    for (int c = 0; c < 6; c++) begin
      #1;
      case (c)
        0: begin
          chk("t4_grant1", grant, 1);
          chk("t4_issue", mgr_rd_en, 1'b1);
          chk("t4_fault_c0", req_fault, 0);
        end
        1: begin
          chk("t4_fault_c1", req_fault, 0);
          req_rd_en[0] = 1'b1;
        end
        2: begin
          chk("t4_fault_done", req_fault, 2'b10);
          chk("t4_busy_done", req_busy, 2'b01);
          req_rd_en[1] = 1'b0;
          mgr_fault = 1'b0;
        end
        3: begin
          chk("t4_next_issue", mgr_rd_en, 1'b1);
          chk("t4_next_grant", grant, 0);
          chk("t4_next_addr", mgr_addr, 32'h400);
          chk("t4_fault_c3", req_fault, 0);
        end
        5: begin
          chk("t4_next_done", req_busy[0], 1'b0);
          clear_req();
        end
        default: ;
      endcase
      adv();
    end

    // Operands change and request drops after issue.
    do_reset();
    lat = 3; nissue = 0;
    req_rd_en = 2'b01; req_addr[0] = 32'h40;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin
        req_addr[0] = 32'h80;
        req_rd_en = 2'b00;
      end
      #1;
      nissue += int'(mgr_rd_en | mgr_wr_en);
      if (c == 0) chk("t5_issue_addr", mgr_addr, 32'h40);
      if (c >= 1 && c <= 3) chk($sformatf("t5_hold_addr_c%0d", c), mgr_addr, 32'h40);
      adv();
    end
    chk("t5_issues", nissue, 1);

    // Async reset mid-transaction.
    do_reset();
    lat = 4; mgr_rd_data = 32'h1111_2222; mgr_fault = 1'b1;
    req_rd_en = 2'b11; req_addr[0] = 32'h500; req_addr[1] = 32'h600;
    #1;
    chk("t6_first_grant", grant, 0);
    adv();
    #1;
    chk("t6_active_addr", mgr_addr, 32'h500);
    rst_n = 1'b0;
    mgr_cnt = 0;
    #1;
    chk("t6_rst_en", {mgr_rd_en, mgr_wr_en}, 0);
    chk("t6_rst_addr", mgr_addr, 0);
    chk("t6_rst_busy", req_busy, 0);
    chk("t6_rst_fault", req_fault, 0);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_rdata", req_rd_data, 0);
    adv();
    adv();
    rst_n = 1'b1;
    mgr_fault = 1'b0;
    #1;
    chk("t6_post_issue", mgr_rd_en, 1'b1);
    chk("t6_post_grant", grant, 0);
    chk("t6_post_addr", mgr_addr, 32'h500);
    lat = 1;
    adv();
    clear_req();
    adv();

    // Randomized traffic against a transaction-level model.
    do_reset();
    act = '0; tx = 1'b0; m_last = N - 1; trem = 0; tg = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(0, 2) == 0) begin
          act[i] = 1'b1;
          op = 2'($urandom_range(1, 3));
          m_rd[i] = op[0]; m_wr[i] = op[1];
          m_addr[i] = $urandom; m_data[i] = $urandom; m_strb[i] = 4'($urandom_range(0, 15));
        end
        req_rd_en[i] = act[i] & m_rd[i];
        req_wr_en[i] = act[i] & m_wr[i];
        req_addr[i] = m_addr[i]; req_wr_data[i] = m_data[i]; req_wr_strobe[i] = m_strb[i];
      end
      e_rd = 0; e_wr = 0; e_addr = '0; e_data = '0; e_strb = '0;
      e_busy = act; e_fault = '0; e_grant = '0; done = 0; chk_g = 0;
      if (!tx) begin
        w = rr_pick(act, m_last);
        if (w >= 0) begin
          e_rd = m_rd[w]; e_wr = m_wr[w] & ~m_rd[w];
          e_addr = m_addr[w]; e_data = m_data[w]; e_strb = m_strb[w];
          t_addr = m_addr[w]; t_data = m_data[w]; t_strb = m_strb[w];
          tx = 1'b1; tg = w;
          lat = $urandom_range(1, 4); trem = lat - 1;
          t_rdata = $urandom; t_fault = ($urandom_range(0, 3) == 0);
          mgr_rd_data = t_rdata; mgr_fault = t_fault;
          e_grant = 1'(w); chk_g = 1'b1;
        end
      end else begin
        e_addr = t_addr; e_data = t_data; e_strb = t_strb;
        e_grant = 1'(tg); chk_g = 1'b1;
        if (trem == 0) begin
          e_busy[tg] = 1'b0; e_fault[tg] = t_fault; done = 1'b1;
        end else begin
          trem--;
        end
      end
      #1;
      chk("rnd_en", {mgr_rd_en, mgr_wr_en}, {e_rd, e_wr});
      chk("rnd_addr", mgr_addr, e_addr);
      chk("rnd_wdata", mgr_wr_data, e_data);
      chk("rnd_strb", mgr_wr_strobe, e_strb);
      chk("rnd_busy", req_busy, e_busy);
      chk("rnd_fault", req_fault, e_fault);
      if (chk_g) chk("rnd_grant", grant, e_grant);
      if (done) begin
        chk("rnd_rdata", req_rd_data, t_rdata);
        act[tg] = 1'b0; m_last = tg; tx = 1'b0;
      end
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
